// File: rtl/load_ext_stage.sv
// load_ext_stage
//   Registered load-data aligner/extender sitting on the MEM->WB boundary.
//   Picks the addressed byte/halfword/word out of a raw little-endian memory
//   word, sign- or zero-extends it to DATA_W and flags misaligned accesses or
//   illegal load modes. A 2-entry (main + skid) buffer decouples WB
//   back-pressure so that in_ready comes straight from a flop.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous flush, drops every held entry
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_mode           000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU
//   in_addr_lo        effective address [1:0]
//   in_word           raw aligned memory word
//   in_tag            destination register tag
//   out_valid/out_ready downstream handshake
//   out_data          extended load result (0 on error)
//   out_tag           tag of the presented entry
//   out_err           misaligned access or illegal mode
module load_ext_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [1:0]        in_addr_lo,
    input  logic [31:0]       in_word,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam logic [2:0] MODE_LB  = 3'b000;
    localparam logic [2:0] MODE_LH  = 3'b001;
    localparam logic [2:0] MODE_LW  = 3'b011;
    localparam logic [2:0] MODE_LBU = 3'b100;
    localparam logic [2:0] MODE_LHU = 3'b101;

    // Encoding is {main_v, skid_v}, so the bits double as the valid flags.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [TAG_W-1:0]    main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic                main_err_q, main_err_d, skid_err_q, skid_err_d;

    logic [7:0]          byte_f;
    logic [15:0]         half_f;
    logic [DATA_W-1:0]   ext_data;
    logic                ext_err;
    logic                in_fire, out_fire;

    // Lane extraction and extension happen before the register so the
    // registered entry is already in writeback form.
    always_comb begin
        byte_f   = in_word[{in_addr_lo, 3'b000} +: 8];
        half_f   = in_word[{in_addr_lo[1], 4'b0000} +: 16];
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            MODE_LB: begin
                ext_data      = {DATA_W{byte_f[7]}};
                ext_data[7:0] = byte_f;
            end
            MODE_LBU: ext_data[7:0] = byte_f;
            MODE_LH: begin
                if (in_addr_lo[0]) begin
                    ext_err = 1'b1;
                end else begin
                    ext_data       = {DATA_W{half_f[15]}};
                    ext_data[15:0] = half_f;
                end
            end
            MODE_LHU: begin
                if (in_addr_lo[0]) ext_err = 1'b1;
                else               ext_data[15:0] = half_f;
            end
            // On a 64-bit datapath LW is the signed word load.
            MODE_LW: begin
                if (in_addr_lo != 2'b00) begin
                    ext_err = 1'b1;
                end else begin
                    ext_data       = {DATA_W{in_word[31]}};
                    ext_data[31:0] = in_word;
                end
            end
            default: ext_err = 1'b1;
        endcase
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = state_q[1] && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        skid_err_d  = skid_err_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                    main_err_d  = ext_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                    main_err_d  = ext_err;
                end else if (in_fire) begin
                    skid_data_d = ext_data;
                    skid_tag_d  = in_tag;
                    skid_err_d  = ext_err;
                    state_d     = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready_q is low here, so only the drain can happen.
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over any same-cycle transfer.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_tag_d  = '0;
            main_err_d  = 1'b0;
        end

        // Registered ready: looks at the next occupancy, not at out_ready.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            main_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            main_err_q  <= main_err_d;
        end
    end

    // Skid contents are only meaningful while skid_v is set; no reset needed.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_tag_q  <= skid_tag_d;
        skid_err_q  <= skid_err_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = state_q[1];
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_load_ext_stage.sv
module tb_load_ext_stage;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_mode;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_word, out_data;
    logic [4:0]  in_tag, out_tag;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err;
    logic [2:0]  w_in_mode;
    logic [1:0]  w_in_addr_lo;
    logic [31:0] w_in_word;
    logic [4:0]  w_in_tag, w_out_tag;
    logic [63:0] w_out_data;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [4:0] seen[$];

    always #5 clk = ~clk;

    load_ext_stage #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_addr_lo(in_addr_lo), .in_word(in_word), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    load_ext_stage #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
        .in_addr_lo(w_in_addr_lo), .in_word(w_in_word), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_tag(w_out_tag), .out_err(w_out_err)
    );

    // Reference: load semantics in plain signed arithmetic, 64-bit result.
    function automatic exp_t model(input logic [2:0] m, input logic [1:0] a,
                                   input logic [31:0] w, input logic [4:0] t);
        exp_t   e;
        longint b, h, v;
        bit     err;
        b   = longint'((w >> (8 * int'(a))) & 32'hFF);
        h   = longint'((w >> (16 * (int'(a) / 2))) & 32'hFFFF);
        v   = 0;
        err = 0;
        case (m)
            3'b000: v = (b >= 128) ? b - 256 : b;
            3'b100: v = b;
            3'b001: if (a % 2 != 0) err = 1; else v = (h >= 32768) ? h - 65536 : h;
            3'b101: if (a % 2 != 0) err = 1; else v = h;
            3'b011: begin
                if (a != 0) err = 1;
                else begin
                    v = longint'(w);
                    if (w[31]) v = v - (longint'(1) << 32);
                end
            end
            default: err = 1;
        endcase
        if (err) v = 0;
        e.data = v;
        e.tag  = t;
        e.err  = err;
        return e;
    endfunction

    // One clock of the 32-bit DUT, checked against an occupancy/queue model.
    task automatic cycle(input bit v, input logic [2:0] m, input logic [1:0] a,
                         input logic [31:0] w, input logic [4:0] t, input bit rdy,
                         input bit fl, input bit rs, output bit acc);
        in_valid = v; in_mode = m; in_addr_lo = a; in_word = w; in_tag = t;
        out_ready = rdy; flush = fl; rst = rs;
        acc = v && in_ready && !fl && !rs;
        checks++;
        if (out_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL out_valid: got %b exp %b", out_valid, q.size() > 0);
        end
        checks++;
        if (in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL in_ready: got %b exp %b (held %0d)", in_ready, q.size() < 2, q.size());
        end
        if (q.size() > 0) begin
            checks++;
            if (out_data !== q[0].data[31:0] || out_tag !== q[0].tag || out_err !== q[0].err) begin
                errors++;
                $display("FAIL out_entry: got data %h tag %0d err %b exp data %h tag %0d err %b",
                         out_data, out_tag, out_err, q[0].data[31:0], q[0].tag, q[0].err);
            end
        end
        if (fl || rs) begin
            q.delete();
        end else begin
            if (out_valid && rdy && q.size() > 0) begin
                seen.push_back(out_tag);
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(m, a, w, t));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 3'b000, 2'b00, 32'h0, 5'd0, 1, 0, 0, acc);
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_mode = 0; in_addr_lo = 0; in_word = 0; in_tag = 0;
        w_flush = 0; w_in_valid = 0; w_out_ready = 1;
        w_in_mode = 0; w_in_addr_lo = 0; w_in_word = 0; w_in_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 ||
            out_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got v%b d%h t%0d e%b r%b exp v0 d0 t0 e0 r1",
                     out_valid, out_data, out_tag, out_err, in_ready);
        end
    endtask

    task automatic test_extension;
        bit acc;
        logic [2:0] modes[6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b011};
        logic [1:0] offs[6]  = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
        logic [31:0] gold[6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        for (int i = 0; i < 6; i++) begin
            cycle(1, modes[i], offs[i], 32'h80FF7F01, 5'(i + 1), 1, 0, 0, acc);
            // Hand-derived value must be on the output one edge later.
            checks++;
            if (out_valid !== 1'b1 || out_data !== gold[i]) begin
                errors++;
                $display("FAIL ext_%0d: got v%b %h exp v1 %h", i, out_valid, out_data, gold[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_errors;
        bit acc;
        logic [2:0] modes[3] = '{3'b001, 3'b011, 3'b110};
        logic [1:0] offs[3]  = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            cycle(1, modes[i], offs[i], 32'hDEADBEEF, 5'd7, 1, 0, 0, acc);
            checks++;
            if (out_err !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'd7) begin
                errors++;
                $display("FAIL err_%0d: got e%b d%h t%0d exp e1 d0 t7", i, out_err, out_data, out_tag);
            end
        end
        idle(2);
    endtask

    task automatic test_back_pressure;
        bit acc;
        int idx = 1;
        seen.delete();
        for (int c = 1; c <= 40; c++) begin
            cycle(idx <= 6, 3'b011, 2'd0, 32'h1000 + 32'(idx), 5'(idx),
                  !(c >= 2 && c <= 5), 0, 0, acc);
            if (acc) idx++;
        end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d exp 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seen[i] !== 5'(i + 1)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %0d exp %0d", i, seen[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_flush;
        bit acc;
        cycle(1, 3'b011, 2'd0, 32'h11, 5'd11, 0, 0, 0, acc);
        cycle(1, 3'b011, 2'd0, 32'h12, 5'd12, 0, 0, 0, acc);
        cycle(1, 3'b011, 2'd0, 32'h13, 5'd13, 0, 1, 0, acc);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got v%b r%b exp v0 r1", out_valid, in_ready);
        end
        idle(3);
    endtask

    task automatic test_reset_midstream;
        bit acc;
        cycle(1, 3'b000, 2'd0, 32'h21, 5'd21, 0, 0, 0, acc);
        cycle(1, 3'b000, 2'd0, 32'h22, 5'd22, 0, 0, 0, acc);
        cycle(1, 3'b000, 2'd0, 32'h23, 5'd23, 1, 0, 1, acc);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got v%b d%h r%b exp v0 d0 r1", out_valid, out_data, in_ready);
        end
        cycle(1, 3'b101, 2'd2, 32'hABCD0000, 5'd9, 1, 0, 0, acc);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000ABCD || out_tag !== 5'd9) begin
            errors++;
            $display("FAIL rst_next: got v%b d%h t%0d exp v1 0000abcd 9", out_valid, out_data, out_tag);
        end
        idle(2);
    endtask

    task automatic test_random;
        bit acc;
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(3, 0) != 0, 3'($urandom), 2'($urandom), $urandom,
                  5'($urandom), $urandom_range(2, 0) != 0, $urandom_range(49, 0) == 0, 0, acc);
        idle(4);
    endtask

    task automatic test_wide64;
        exp_t prev;
        logic [2:0] m;
        logic [1:0] a;
        logic [31:0] w;
        w_in_valid = 1; w_out_ready = 1; w_in_tag = 5'd3;
        w_in_mode = 3'b000; w_in_addr_lo = 0; w_in_word = 32'h00000080;
        @(posedge clk); #1;
        w_in_mode = 3'b101; w_in_word = 32'h00008000;
        checks++;
        if (w_out_valid !== 1'b1 || w_out_data !== 64'hFFFFFFFFFFFFFF80) begin
            errors++;
            $display("FAIL w64_lb: got v%b %h exp v1 ffffffffffffff80", w_out_valid, w_out_data);
        end
        @(posedge clk); #1;
        checks++;
        if (w_out_data !== 64'h0000000000008000) begin
            errors++;
            $display("FAIL w64_lhu: got %h exp 0000000000008000", w_out_data);
        end
        for (int i = 0; i < 30; i++) begin
            m = 3'($urandom); a = 2'($urandom); w = $urandom;
            w_in_mode = m; w_in_addr_lo = a; w_in_word = w; w_in_tag = 5'(i);
            if (i > 0) begin
                checks++;
                if (w_out_data !== prev.data || w_out_err !== prev.err || w_out_tag !== prev.tag) begin
                    errors++;
                    $display("FAIL w64_rand: got %h e%b t%0d exp %h e%b t%0d",
                             w_out_data, w_out_err, w_out_tag, prev.data, prev.err, prev.tag);
                end
            end
            prev = model(m, a, w, 5'(i));
            @(posedge clk); #1;
        end
        w_in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_extension();
        test_errors();
        test_back_pressure();
        test_flush();
        test_reset_midstream();
        test_random();
        test_wide64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
